// File: rtl/status_unit_if.sv
// status_unit_if: request/result handshake, status outputs and sticky controls of status_unit
interface status_unit_if #(
    parameter int N         = 8,
    parameter int ERR_CNT_W = 8
);
    logic                     i_valid;
    logic                     o_ready;
    logic [N-1:0]             i_byte;
    logic [1:0]               i_op;
    logic                     i_carry;
    logic                     i_ovf;
    logic                     i_ERR_shl;
    logic                     i_ERR_chg;
    logic                     o_valid;
    logic                     i_ready;
    logic [3:0]               o_status;
    logic [$clog2(N+1)-1:0]   o_zeros;
    logic                     i_clr;
    logic                     o_sticky_err;
    logic                     o_sticky_ovf;
    logic [ERR_CNT_W-1:0]     o_err_cnt;

    modport master (
        output i_valid, i_byte, i_op, i_carry, i_ovf, i_ERR_shl, i_ERR_chg, i_ready, i_clr,
        input  o_ready, o_valid, o_status, o_zeros, o_sticky_err, o_sticky_ovf, o_err_cnt
    );
    modport slave (
        input  i_valid, i_byte, i_op, i_carry, i_ovf, i_ERR_shl, i_ERR_chg, i_ready, i_clr,
        output o_ready, o_valid, o_status, o_zeros, o_sticky_err, o_sticky_ovf, o_err_cnt
    );
endinterface

// File: rtl/status_unit.sv
// status_unit: counts zero bits of an ALU result BPC bits per cycle and reports status flags, sticky flags and an error counter
module status_unit #(
    parameter int N         = 8,
    parameter int BPC       = 1,
    parameter int ERR_CNT_W = 8
) (
    input logic        i_clk,
    input logic        i_rst,
    status_unit_if.slave bus
);
    localparam int S  = N / BPC;
    localparam int ZW = $clog2(N + 1);
    localparam int IW = $clog2(S + 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         sh_q, sh_d;
    logic [1:0]           op_q, op_d;
    logic                 carry_q, carry_d, ovf_q, ovf_d, eshl_q, eshl_d, echg_q, echg_d;
    logic [ZW-1:0]        acc_q, acc_d, zeros_q, zeros_d, slice_z, zeros_n;
    logic [IW-1:0]        idx_q, idx_d;
    logic [3:0]           status_q, status_d;
    logic                 sticky_err_q, sticky_err_d, sticky_ovf_q, sticky_ovf_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 accept, last, xfer, err_sel, ovf_sel, ev_err;

    assign accept = state_q == IDLE && bus.i_valid;
    assign last   = state_q == COUNT && idx_q == IW'(S - 1);
    assign xfer   = state_q == DONE && bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? COUNT : last ? DONE : xfer ? IDLE : state_q;
    end

    always_comb begin
        bus.o_ready = state_q == IDLE;
        bus.o_valid = state_q == DONE;
    end

    assign bus.o_status     = status_q;
    assign bus.o_zeros      = zeros_q;
    assign bus.o_sticky_err = sticky_err_q;
    assign bus.o_sticky_ovf = sticky_ovf_q;
    assign bus.o_err_cnt    = err_cnt_q;

    // The operand shifts right so the current slice always sits in the low BPC bits.
    always_comb begin
        slice_z = '0;
        for (int b = 0; b < BPC; b++) slice_z = slice_z + ZW'(!sh_q[b]);
        zeros_n  = acc_q + slice_z;
        ovf_sel  = op_q == 2'b00 ? carry_q : op_q == 2'b10 ? ovf_q : 1'b0;
        err_sel  = op_q == 2'b10 ? eshl_q : op_q == 2'b11 ? echg_q : 1'b0;
        sh_d     = accept ? bus.i_byte : state_q == COUNT ? sh_q >> BPC : sh_q;
        {op_d, carry_d, ovf_d, eshl_d, echg_d} = accept
            ? {bus.i_op, bus.i_carry, bus.i_ovf, bus.i_ERR_shl, bus.i_ERR_chg}
            : {op_q, carry_q, ovf_q, eshl_q, echg_q};
        acc_d    = accept ? '0 : state_q == COUNT ? zeros_n : acc_q;
        idx_d    = accept ? '0 : state_q == COUNT ? idx_q + IW'(1) : idx_q;
        zeros_d  = last ? zeros_n : zeros_q;
        status_d = last ? {zeros_n == ZW'(1), ovf_sel, ~zeros_n[0], err_sel} : status_q;
        ev_err   = xfer && status_q[0];
        // A transfer on the same edge as a clear still records its event.
        sticky_err_d = (sticky_err_q && !bus.i_clr) || ev_err;
        sticky_ovf_d = (sticky_ovf_q && !bus.i_clr) || (xfer && status_q[2]);
        err_cnt_d    = bus.i_clr ? ERR_CNT_W'(ev_err)
                                 : err_cnt_q + ERR_CNT_W'(ev_err && err_cnt_q != '1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_q         <= '0;
            op_q         <= '0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            eshl_q       <= 1'b0;
            echg_q       <= 1'b0;
            acc_q        <= '0;
            idx_q        <= '0;
            zeros_q      <= '0;
            status_q     <= '0;
            sticky_err_q <= 1'b0;
            sticky_ovf_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            sh_q         <= sh_d;
            op_q         <= op_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
            eshl_q       <= eshl_d;
            echg_q       <= echg_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            zeros_q      <= zeros_d;
            status_q     <= status_d;
            sticky_err_q <= sticky_err_d;
            sticky_ovf_q <= sticky_ovf_d;
            err_cnt_q    <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_status_unit.sv
// tb_status_unit: table-driven and randomized checks of status_unit against a flag-rule reference model
module tb_status_unit;
    logic clk, rst;
    int   tests, fails;
    logic s_err, s_ovf;
    int   cnt;

    status_unit_if #(.N(8), .ERR_CNT_W(2)) b1 ();
    status_unit_if #(.N(8), .ERR_CNT_W(2)) b4 ();

    status_unit #(.N(8), .BPC(1), .ERR_CNT_W(2)) dut  (.i_clk(clk), .i_rst(rst), .bus(b1));
    status_unit #(.N(8), .BPC(4), .ERR_CNT_W(2)) dut4 (.i_clk(clk), .i_rst(rst), .bus(b4));

    typedef struct {
        logic [7:0] by;
        logic [1:0] op;
        logic       c, o, es, ec;
        int         hold;
        logic       clr;
        logic [3:0] xs;
        int         xz;
    } vec_t;

    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_status(input logic [7:0] by, input logic [1:0] op,
                                              input logic c, o, es, ec);
        int z;
        logic err, ov;
        z   = 8 - $countones(by);
        err = (op == 2 && es) || (op == 3 && ec);
        ov  = (op == 0 && c) || (op == 2 && o);
        return {z == 1, ov, z % 2 == 0, err};
    endfunction

    task automatic run_op(input logic [7:0] by, input logic [1:0] op, input logic c, o, es, ec,
                          input int hold, input logic clr, input logic [3:0] xs, input int xz);
        int cyc;
        check("ready_idle", b1.o_ready, 1);
        b1.i_valid = 1'b1; b1.i_byte = by; b1.i_op = op;
        b1.i_carry = c; b1.i_ovf = o; b1.i_ERR_shl = es; b1.i_ERR_chg = ec;
        tick();
        b1.i_valid = 1'b0; b1.i_byte = 8'($urandom); b1.i_op = 2'($urandom);
        {b1.i_carry, b1.i_ovf, b1.i_ERR_shl, b1.i_ERR_chg} = 4'($urandom);
        cyc = 0;
        while (b1.o_valid !== 1'b1 && cyc < 40) begin
            check("count_not_ready", b1.o_ready, 0);
            tick();
            cyc++;
        end
        check("latency", cyc, 8);
        check("zeros", b1.o_zeros, xz);
        check("status", b1.o_status, xs);
        for (int i = 0; i < hold; i++) begin
            b1.i_valid = 1'b1;
            tick();
            check("hold_handshake", {b1.o_valid, b1.o_ready}, 2'b10);
            check("hold_result", {b1.o_status, b1.o_zeros}, {xs, 4'(xz)});
        end
        b1.i_valid = 1'b0;
        b1.i_ready = 1'b1; b1.i_clr = clr;
        tick();
        b1.i_ready = 1'b0; b1.i_clr = 1'b0;
        if (clr) begin s_err = 0; s_ovf = 0; cnt = 0; end
        if (xs[0]) begin s_err = 1; cnt = cnt < 3 ? cnt + 1 : cnt; end
        if (xs[2]) s_ovf = 1;
        check("xfer_handshake", {b1.o_valid, b1.o_ready}, 2'b01);
        check("sticky_err", b1.o_sticky_err, s_err);
        check("sticky_ovf", b1.o_sticky_ovf, s_ovf);
        check("err_cnt", b1.o_err_cnt, cnt);
        check("retain_idle", {b1.o_status, b1.o_zeros}, {xs, 4'(xz)});
    endtask

    initial begin
        bit saw_valid;
        int cyc;
        logic [7:0] by;
        logic [1:0] op;
        logic [3:0] fl;
        vecs[0] = '{8'hFF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'b0010, 0};
        vecs[1] = '{8'hFE, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'b1100, 1};
        vecs[2] = '{8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'b0011, 8};
        vecs[3] = '{8'hF8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 4'b0100, 3};
        vecs[4] = '{8'h0F, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'b0011, 4};
        vecs[5] = '{8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 7};
        vecs[6] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 4'b0111, 6};
        vecs[7] = '{8'h7F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 4'b1001, 1};
        vecs[8] = '{8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 4'b0011, 8};
        tests = 0; fails = 0; s_err = 0; s_ovf = 0; cnt = 0;
        {b1.i_valid, b1.i_byte, b1.i_op, b1.i_carry, b1.i_ovf, b1.i_ERR_shl, b1.i_ERR_chg, b1.i_ready, b1.i_clr} = '0;
        {b4.i_valid, b4.i_byte, b4.i_op, b4.i_carry, b4.i_ovf, b4.i_ERR_shl, b4.i_ERR_chg, b4.i_ready, b4.i_clr} = '0;
        rst = 1'b1;
        tick();
        check("rst_ready", b1.o_ready, 1);
        check("rst_outputs", {b1.o_valid, b1.o_status, b1.o_zeros, b1.o_sticky_err, b1.o_sticky_ovf, b1.o_err_cnt}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_after_rst", {b1.o_valid, b1.o_ready}, 2'b01);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].by, vecs[i].op, vecs[i].c, vecs[i].o, vecs[i].es, vecs[i].ec,
                   vecs[i].hold, vecs[i].clr, vecs[i].xs, vecs[i].xz);
            if (i == 7) check("err_cnt_saturated", b1.o_err_cnt, 3);
            if (i == 8) check("clr_with_error", b1.o_err_cnt, 1);
        end

        b1.i_valid = 1'b1; b1.i_byte = 8'h55; b1.i_op = 2'b10; b1.i_ovf = 1'b1; b1.i_ERR_shl = 1'b1;
        b1.i_ready = 1'b1;
        tick();
        b1.i_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_err = 0; s_ovf = 0; cnt = 0;
        check("abort_ready", b1.o_ready, 1);
        check("abort_outputs", {b1.o_valid, b1.o_status, b1.o_zeros, b1.o_sticky_err, b1.o_sticky_ovf, b1.o_err_cnt}, 0);
        saw_valid = 0;
        repeat (12) begin
            tick();
            saw_valid |= b1.o_valid;
        end
        check("abort_no_valid", saw_valid, 0);
        check("abort_no_sticky", {b1.o_sticky_err, b1.o_sticky_ovf, b1.o_err_cnt}, 0);
        b1.i_ready = 1'b0;

        b4.i_valid = 1'b1; b4.i_byte = 8'h0F; b4.i_op = 2'b01;
        tick();
        b4.i_valid = 1'b0;
        cyc = 0;
        while (b4.o_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        check("bpc4_latency", cyc, 2);
        check("bpc4_zeros", b4.o_zeros, 4);
        check("bpc4_status", b4.o_status, 4'b0010);
        b4.i_ready = 1'b1;
        tick();
        b4.i_ready = 1'b0;
        check("bpc4_idle", {b4.o_valid, b4.o_ready}, 2'b01);

        for (int i = 0; i < 30; i++) begin
            by = 8'($urandom); op = 2'($urandom); fl = 4'($urandom);
            run_op(by, op, fl[0], fl[1], fl[2], fl[3], int'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, ref_status(by, op, fl[0], fl[1], fl[2], fl[3]),
                   8 - $countones(by));
        end

        run_op(8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'b0110, 8);
        run_op(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'b0011, 8);
        b1.i_clr = 1'b1;
        tick();
        b1.i_clr = 1'b0;
        check("clr_idle", {b1.o_sticky_err, b1.o_sticky_ovf, b1.o_err_cnt}, 0);
        check("clr_keeps_result", {b1.o_status, b1.o_zeros}, {4'b0011, 4'd8});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/status_unit.md
STATUS_UNIT -- requirements
Module: status_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N, 8: operand width in bits; N >= 2.
- BPC, 1: bits examined per COUNT cycle; N SHALL be an integer multiple of BPC.
- ERR_CNT_W, 8: width of the saturating error-event counter.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk, in, 1: single clock; all logic on the rising edge.
- i_rst, in, 1: synchronous, active-high reset.
- i_valid, in, 1: input request valid.
- o_ready, out, 1: unit idle and able to accept a request.
- i_byte, in, N: ALU result to be examined.
- i_op, in, 2: operation code. 00 subtractor, 01 comparator, 10 shifter, 11 bit changer.
- i_carry, in, 1: subtractor carry.
- i_ovf, in, 1: shifter overflow.
- i_ERR_shl, in, 1: shifter error.
- i_ERR_chg, in, 1: bit-changer error.
- o_valid, out, 1: result valid.
- i_ready, in, 1: downstream accepts the result.
- o_status, out, 4: bit0 ERROR, bit1 EVEN, bit2 OVF, bit3 SINGLE.
- o_zeros, out, $clog2(N+1): number of zero bits in the captured operand.
- i_clr, in, 1: clear the sticky flags and the error counter.
- o_sticky_err, out, 1: sticky ERROR flag.
- o_sticky_ovf, out, 1: sticky OVF flag.
- o_err_cnt, out, ERR_CNT_W: saturating count of delivered results that had ERROR set.
REQ-003 Clock and reset SHALL be exactly as decided: one clock i_clk; i_rst is synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, COUNT and DONE. o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-005 In IDLE, when i_valid=1 and o_ready=1 at an edge, the unit SHALL capture i_byte, i_op, i_carry, i_ovf, i_ERR_shl and i_ERR_chg, clear the zero accumulator, and go to COUNT. All inputs SHALL be ignored while the unit is not in IDLE.
REQ-006 In COUNT, the unit SHALL add the zero count of slice k (BPC bits, LSB slice first) to the accumulator on each cycle. After N/BPC cycles it SHALL go to DONE.
REQ-007 o_valid SHALL rise exactly N/BPC cycles after the accepting edge.
REQ-008 The ERROR and OVF bits SHALL be selected from the captured operands by captured op:
- op 00: OVF=carry, ERROR=0.
- op 01: OVF=0, ERROR=0.
- op 10: OVF=ovf, ERROR=ERR_shl.
- op 11: OVF=0, ERROR=ERR_chg.
REQ-009 The EVEN and SINGLE bits SHALL be set from zeros:
- zeros even (0 counts as even): EVEN=1, SINGLE=0.
- zeros==1: EVEN=0, SINGLE=1.
- otherwise: both 0.
REQ-010 o_status and o_zeros SHALL be registered and SHALL hold stable while in DONE.
REQ-011 In DONE, when i_ready=1, the result SHALL transfer and the FSM SHALL return to IDLE. While i_ready=0, the FSM SHALL stay in DONE indefinitely with all outputs held.
REQ-012 On the transfer edge, the sticky flags SHALL update:
- o_sticky_err is set if ERROR=1.
- o_sticky_ovf is set if OVF=1.
REQ-013 On the transfer edge, if ERROR=1, o_err_cnt SHALL increment, saturating at 2^ERR_CNT_W-1 with no wrap.
REQ-014 i_clr=1 SHALL zero o_sticky_err, o_sticky_ovf and o_err_cnt at the next edge, in any state.
REQ-015 If i_clr=1 and a transfer occur on the same edge, the new event SHALL win: each sticky flag is set if its bit is set, and o_err_cnt becomes 1 if ERROR=1, else 0.
REQ-016 o_status and o_zeros SHALL retain the last delivered values in IDLE and COUNT; they SHALL be 0 after reset.

Reset
REQ-017 While i_rst=1 at an edge, the unit SHALL enter IDLE and force the following to 0:
- o_valid, o_status, o_zeros, the accumulator, the slice index, o_sticky_err, o_sticky_ovf, o_err_cnt.
REQ-018 o_ready SHALL be 1 from the first edge after i_rst is sampled high.
REQ-019 Reset in COUNT or DONE SHALL abort the operation: no result is delivered and no sticky or counter update occurs. i_rst SHALL take priority over i_clr and over handshakes.

Verification (N=8, BPC=1, ERR_CNT_W=2 unless stated)
REQ-020 The bench SHALL cover at least the following scenarios:
- i_byte=8'hFF, op=01 -> o_valid exactly 8 cycles after accept; o_zeros=0; o_status=4'b0010.
- i_byte=8'hFE, op=10, ovf=1, ERR_shl=0 -> o_zeros=1; o_status=4'b1100; o_sticky_ovf=1 after transfer.
- i_byte=8'h00, op=11, ERR_chg=1 -> o_zeros=8; o_status=4'b0011; o_sticky_err=1; o_err_cnt=1.
- i_byte=8'hF8, op=00, carry=1 with i_ready=0 for 5 cycles -> o_status=4'b0100 and o_zeros=3 held; o_ready=0; a new i_valid is ignored; transfer when i_ready=1.
- Four error results -> o_err_cnt=3 (saturates). Then i_clr together with an error transfer -> o_err_cnt=1.
- i_rst pulsed in COUNT cycle 4 -> all outputs 0; o_ready=1 on the next cycle; no o_valid pulse.
- BPC=4 build: i_byte=8'h0F -> o_zeros=4; o_valid 2 cycles after accept.
